// File: rtl/ddr_device_responder_if.sv
// Command/data bus between a DDR controller and the device-side responder.
// Both DDR beats of one CLK100 cycle travel as one 32-bit word: [15:0] is the
// first beat, [31:16] the second.
interface ddr_device_responder_if;
  logic        CS_N;
  logic        RAS_N;
  logic        CAS_N;
  logic        WE_N;
  logic [1:0]  BA;
  logic [11:0] ADDR;
  logic [31:0] WDATA;
  logic [3:0]  WDM;
  logic [31:0] RDATA;
  logic        RVALID;
  logic        DQS_OE;
  logic        ERR;
  logic [15:0] REF_CNT;

  modport master (
    output CS_N, RAS_N, CAS_N, WE_N, BA, ADDR, WDATA, WDM,
    input  RDATA, RVALID, DQS_OE, ERR, REF_CNT
  );

  modport slave (
    input  CS_N, RAS_N, CAS_N, WE_N, BA, ADDR, WDATA, WDM,
    output RDATA, RVALID, DQS_OE, ERR, REF_CNT
  );
endinterface

// File: rtl/ddr_device_responder.sv
// SDRAM device-side model: decodes commands, tracks open rows per bank,
// stores masked write bursts and returns read bursts after CAS latency.
//
// state              | meaning
// r_rd_left != 0     | read burst fetching one word per cycle
// r_wr_left != 0     | write burst storing one word per cycle
// r_s0_v / r_s1_v    | fetched read words in flight (CL2 leaves s0, CL3 leaves s1)
module ddr_device_responder #(
  parameter int ROW_BITS = 2,
  parameter int COL_BITS = 6
) (
  input  logic                  CLK100,
  input  logic                  RESET_N,
  ddr_device_responder_if.slave bus
);
  localparam int AW    = 2 + ROW_BITS + COL_BITS;
  localparam int DEPTH = 1 << AW;

  logic [31:0]          r_mem [DEPTH];
  logic [3:0]           r_open;
  logic [ROW_BITS-1:0]  r_row [4];
  logic                 r_cl3;
  logic [1:0]           r_bl;          // 0: 1 word, 1: 2 words, 2: 4 words
  logic [2:0]           r_rd_left, r_wr_left;
  logic [1:0]           r_rd_idx, r_wr_idx;
  logic [1:0]           r_rd_ba, r_wr_ba;
  logic [ROW_BITS-1:0]  r_rd_row, r_wr_row;
  logic [COL_BITS-1:0]  r_rd_col, r_wr_col;
  logic                 r_s0_v, r_s0_cl3, r_s1_v;
  logic [31:0]          r_s0_d, r_s1_d;
  logic [31:0]          r_rdata;
  logic                 r_rvalid, r_dqs, r_err;
  logic [15:0]          r_ref;

  logic                 w_act, w_rd, w_wr, w_pre, w_ref, w_lm;
  logic                 w_any_open, w_bank_open, w_cl_ok, w_bl_ok;
  logic                 w_acc_rd, w_acc_wr, w_acc_lm, w_term, w_err;
  logic [2:0]           w_bl_words;
  logic [COL_BITS-1:0]  w_mask;
  logic                 w_fetch, w_wen, w_fwd, w_out_v;
  logic [AW-1:0]        w_raddr, w_waddr;
  logic [31:0]          w_rword, w_out_d;
  logic                 w_unused_addr;

  // Sequential-within-block column: low log2(BL) bits wrap, upper bits fixed.
  function automatic logic [COL_BITS-1:0] f_burst_col(input logic [COL_BITS-1:0] base,
                                                      input logic [1:0] idx,
                                                      input logic [COL_BITS-1:0] mask);
    return (base & ~mask) | ((base + COL_BITS'(idx)) & mask);
  endfunction

  assign w_unused_addr = ^bus.ADDR;

  // Command decode, legality and burst-termination detection.
  always_comb begin
    w_act       = !bus.CS_N && {bus.RAS_N, bus.CAS_N, bus.WE_N} == 3'b011;
    w_rd        = !bus.CS_N && {bus.RAS_N, bus.CAS_N, bus.WE_N} == 3'b101;
    w_wr        = !bus.CS_N && {bus.RAS_N, bus.CAS_N, bus.WE_N} == 3'b100;
    w_pre       = !bus.CS_N && {bus.RAS_N, bus.CAS_N, bus.WE_N} == 3'b010;
    w_ref       = !bus.CS_N && {bus.RAS_N, bus.CAS_N, bus.WE_N} == 3'b001;
    w_lm        = !bus.CS_N && {bus.RAS_N, bus.CAS_N, bus.WE_N} == 3'b000;
    w_any_open  = |r_open;
    w_bank_open = r_open[bus.BA];
    w_cl_ok     = bus.ADDR[6:4] == 3'b010 || bus.ADDR[6:4] == 3'b011;
    w_bl_ok     = bus.ADDR[2:0] == 3'b001 || bus.ADDR[2:0] == 3'b010 || bus.ADDR[2:0] == 3'b011;
    w_acc_rd    = w_rd && w_bank_open;
    w_acc_wr    = w_wr && w_bank_open;
    w_acc_lm    = w_lm && !w_any_open;
    w_term      = w_acc_rd || w_acc_wr || w_pre || w_acc_lm;
    w_err       = (w_act && w_bank_open) || ((w_rd || w_wr) && !w_bank_open) ||
                  (w_ref && w_any_open) || (w_lm && w_any_open) ||
                  (w_acc_lm && (!w_cl_ok || !w_bl_ok));
    w_bl_words  = (r_bl == 2'd0) ? 3'd1 : (r_bl == 2'd1) ? 3'd2 : 3'd4;
    w_mask      = COL_BITS'(w_bl_words - 3'd1);
  end

  // Storage port addressing; a write landing on the word being fetched is forwarded.
  always_comb begin
    w_fetch = w_acc_rd || (r_rd_left != 3'd0 && !w_term);
    w_raddr = w_acc_rd ? {bus.BA, r_row[bus.BA], bus.ADDR[COL_BITS-1:0]}
                       : {r_rd_ba, r_rd_row, f_burst_col(r_rd_col, r_rd_idx, w_mask)};
    w_wen   = r_wr_left != 3'd0;
    w_waddr = {r_wr_ba, r_wr_row, f_burst_col(r_wr_col, r_wr_idx, w_mask)};
    w_fwd   = w_wen && (w_waddr == w_raddr);
    w_rword = r_mem[w_raddr];
    for (int b = 0; b < 4; b++)
      if (w_fwd && !bus.WDM[b]) w_rword[8*b +: 8] = bus.WDATA[8*b +: 8];
    w_out_v = (r_s0_v && !r_s0_cl3) || r_s1_v;
    w_out_d = (r_s0_v && !r_s0_cl3) ? r_s0_d : r_s1_d;
  end

  // Storage array and read-data pipeline payload (contents are not reset).
  always_ff @(posedge CLK100) begin
    if (w_wen)
      for (int b = 0; b < 4; b++)
        if (!bus.WDM[b]) r_mem[w_waddr][8*b +: 8] <= bus.WDATA[8*b +: 8];
    r_s0_d <= w_rword;
    r_s1_d <= r_s0_d;
  end

  // Bank/mode state, burst sequencing and registered outputs.
  always_ff @(posedge CLK100 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_open    <= '0;
      for (int i = 0; i < 4; i++) r_row[i] <= '0;
      r_cl3     <= 1'b0;
      r_bl      <= 2'd1;
      r_rd_left <= '0; r_rd_idx <= '0; r_rd_ba <= '0; r_rd_row <= '0; r_rd_col <= '0;
      r_wr_left <= '0; r_wr_idx <= '0; r_wr_ba <= '0; r_wr_row <= '0; r_wr_col <= '0;
      r_s0_v    <= 1'b0;
      r_s0_cl3  <= 1'b0;
      r_s1_v    <= 1'b0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_dqs     <= 1'b0;
      r_err     <= 1'b0;
      r_ref     <= '0;
    end else begin
      r_err <= w_err;
      if (w_act && !w_bank_open) begin
        r_open[bus.BA] <= 1'b1;
        r_row[bus.BA]  <= bus.ADDR[ROW_BITS-1:0];
      end
      if (w_pre) begin
        if (bus.ADDR[10]) r_open <= '0;
        else              r_open[bus.BA] <= 1'b0;
      end
      if (w_ref && !w_any_open && r_ref != 16'hFFFF) r_ref <= r_ref + 16'd1;
      if (w_acc_lm) begin
        if (w_cl_ok) r_cl3 <= bus.ADDR[4];
        if (w_bl_ok) r_bl  <= bus.ADDR[1:0] - 2'd1;
      end

      if (w_acc_rd) begin
        r_rd_left <= w_bl_words - 3'd1;
        r_rd_idx  <= 2'd1;
        r_rd_ba   <= bus.BA;
        r_rd_row  <= r_row[bus.BA];
        r_rd_col  <= bus.ADDR[COL_BITS-1:0];
      end else if (w_term) begin
        r_rd_left <= '0;
      end else if (r_rd_left != 3'd0) begin
        r_rd_left <= r_rd_left - 3'd1;
        r_rd_idx  <= r_rd_idx + 2'd1;
      end

      if (w_acc_wr) begin
        r_wr_left <= w_bl_words;
        r_wr_idx  <= 2'd0;
        r_wr_ba   <= bus.BA;
        r_wr_row  <= r_row[bus.BA];
        r_wr_col  <= bus.ADDR[COL_BITS-1:0];
      end else if (w_term) begin
        r_wr_left <= '0;
      end else if (r_wr_left != 3'd0) begin
        r_wr_left <= r_wr_left - 3'd1;
        r_wr_idx  <= r_wr_idx + 2'd1;
      end

      r_s0_v   <= w_fetch;
      r_s0_cl3 <= r_cl3;
      r_s1_v   <= r_s0_v && r_s0_cl3;
      r_rvalid <= w_out_v;
      if (w_out_v) r_rdata <= w_out_d;
      // Strobe covers every output word plus a one-cycle preamble before it.
      r_dqs    <= w_out_v || (w_fetch && !r_cl3) || (r_s0_v && r_s0_cl3);
    end
  end

  assign bus.RDATA   = r_rdata;
  assign bus.RVALID  = r_rvalid;
  assign bus.DQS_OE  = r_dqs;
  assign bus.ERR     = r_err;
  assign bus.REF_CNT = r_ref;
endmodule

// File: tb/tb_ddr_device_responder.sv
// Directed bench for ddr_device_responder: mode, write/read, wrap, masks,
// illegal commands, burst interruption and reset abort.
module tb_ddr_device_responder;
  localparam logic [2:0] C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100,
                         C_PRE = 3'b010, C_REF = 3'b001, C_LM = 3'b000;

  logic CLK100 = 1'b0;
  logic RESET_N;
  int   npass = 0;
  int   ntot  = 0;
  logic        cv [16];
  logic        cq [16];
  logic [31:0] cd [16];
  logic [31:0] exp6 [6];
  logic        acc;

  ddr_device_responder_if bus();
  ddr_device_responder dut (.CLK100(CLK100), .RESET_N(RESET_N), .bus(bus));

  always #5 CLK100 = ~CLK100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge CLK100);
    #1;
  endtask

  task automatic nop;
    bus.CS_N = 1'b1;
    {bus.RAS_N, bus.CAS_N, bus.WE_N} = 3'b111;
  endtask

  task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [11:0] a);
    bus.CS_N = 1'b0;
    {bus.RAS_N, bus.CAS_N, bus.WE_N} = c;
    bus.BA   = ba;
    bus.ADDR = a;
    tick();
    nop();
  endtask

  task automatic cap(input int n);
    for (int i = 1; i <= n; i++) begin
      cv[i] = bus.RVALID;
      cq[i] = bus.DQS_OE;
      cd[i] = bus.RDATA;
      if (i < n) tick();
    end
  endtask

  initial begin
    RESET_N = 1'b0;
    nop();
    bus.BA = 2'd0; bus.ADDR = 12'd0; bus.WDATA = 32'd0; bus.WDM = 4'd0;
    tick(); tick();
    chk("rst_rdata", bus.RDATA, 32'd0);
    chk("rst_rvalid", bus.RVALID, 32'd0);
    chk("rst_dqs", bus.DQS_OE, 32'd0);
    chk("rst_err", bus.ERR, 32'd0);
    chk("rst_ref", bus.REF_CNT, 32'd0);
    RESET_N = 1'b1;
    tick();

    // CL2 BL2, open bank 1 row 3, write col4/col5
    issue(C_LM, 2'd0, 12'h022);
    chk("lm_err", bus.ERR, 32'd0);
    issue(C_ACT, 2'd1, 12'd3);
    chk("act_err", bus.ERR, 32'd0);
    issue(C_WR, 2'd1, 12'd4);
    chk("wr_err", bus.ERR, 32'd0);
    bus.WDATA = 32'h1111_2222; bus.WDM = 4'h0; tick();
    bus.WDATA = 32'h3333_4444; tick();
    bus.WDM = 4'hF;

    // CL2 read of col4
    issue(C_RD, 2'd1, 12'd4);
    cap(4);
    chk("rd2_rv1", cv[1], 32'd0);
    chk("rd2_dq1", cq[1], 32'd1);
    chk("rd2_rv2", cv[2], 32'd1);
    chk("rd2_d2", cd[2], 32'h1111_2222);
    chk("rd2_rv3", cv[3], 32'd1);
    chk("rd2_d3", cd[3], 32'h3333_4444);
    chk("rd2_dq3", cq[3], 32'd1);
    chk("rd2_rv4", cv[4], 32'd0);
    chk("rd2_dq4", cq[4], 32'd0);
    chk("rd2_hold", cd[4], 32'h3333_4444);

    // CL3 wrap read starting at col5
    issue(C_PRE, 2'd0, 12'h400);
    issue(C_LM, 2'd0, 12'h032);
    chk("lm3_err", bus.ERR, 32'd0);
    issue(C_ACT, 2'd1, 12'd3);
    issue(C_RD, 2'd1, 12'd5);
    cap(5);
    chk("rd3_dq1", cq[1], 32'd0);
    chk("rd3_rv2", cv[2], 32'd0);
    chk("rd3_dq2", cq[2], 32'd1);
    chk("rd3_rv3", cv[3], 32'd1);
    chk("rd3_d3", cd[3], 32'h3333_4444);
    chk("rd3_d4", cd[4], 32'h1111_2222);
    chk("rd3_rv5", cv[5], 32'd0);

    // Masked write to col4 (low half kept), col5 fully masked
    issue(C_WR, 2'd1, 12'd4);
    bus.WDATA = 32'hAAAA_BBBB; bus.WDM = 4'b0011; tick();
    bus.WDATA = 32'h0; bus.WDM = 4'hF; tick();
    issue(C_RD, 2'd1, 12'd4);
    cap(4);
    chk("mask_d", cd[3], 32'hAAAA_2222);
    chk("mask_d5", cd[4], 32'h3333_4444);

    // Illegal commands
    issue(C_RD, 2'd0, 12'd0);
    chk("rdclosed_err", bus.ERR, 32'd1);
    acc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      acc = acc | bus.RVALID;
      if (i == 1) chk("err_pulse", bus.ERR, 32'd0);
      tick();
    end
    chk("rdclosed_rv", acc, 32'd0);
    issue(C_ACT, 2'd1, 12'd3);
    chk("actopen_err", bus.ERR, 32'd1);
    issue(C_REF, 2'd0, 12'd0);
    chk("refopen_err", bus.ERR, 32'd1);
    tick();
    chk("refopen_cnt", bus.REF_CNT, 32'd0);
    issue(C_PRE, 2'd0, 12'h400);
    chk("pre_err", bus.ERR, 32'd0);
    issue(C_REF, 2'd0, 12'd0);
    chk("ref_err", bus.ERR, 32'd0);
    chk("ref_cnt", bus.REF_CNT, 32'd1);

    // BL4 CL2: fill cols 0..3 and 8..11 of bank 2 row 1
    issue(C_LM, 2'd0, 12'h023);
    issue(C_ACT, 2'd2, 12'd1);
    issue(C_WR, 2'd2, 12'd0);
    for (int i = 0; i < 4; i++) begin
      bus.WDATA = 32'hC0DE_0000 + 32'(i); bus.WDM = 4'h0; tick();
    end
    bus.WDM = 4'hF;
    issue(C_WR, 2'd2, 12'd8);
    for (int i = 0; i < 4; i++) begin
      bus.WDATA = 32'hBEEF_0008 + 32'(i); bus.WDM = 4'h0; tick();
    end
    bus.WDM = 4'hF;

    // READ col0 interrupted by READ col8 two cycles later
    issue(C_RD, 2'd2, 12'd0);
    for (int i = 1; i <= 9; i++) begin
      cv[i] = bus.RVALID; cq[i] = bus.DQS_OE; cd[i] = bus.RDATA;
      if (i == 2) begin
        bus.CS_N = 1'b0; {bus.RAS_N, bus.CAS_N, bus.WE_N} = C_RD;
        bus.BA = 2'd2; bus.ADDR = 12'd8;
      end else nop();
      tick();
    end
    exp6[0] = 32'hC0DE_0000; exp6[1] = 32'hC0DE_0001; exp6[2] = 32'hBEEF_0008;
    exp6[3] = 32'hBEEF_0009; exp6[4] = 32'hBEEF_000A; exp6[5] = 32'hBEEF_000B;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("int_rv%0d", i + 2), cv[i+2], 32'd1);
      chk($sformatf("int_d%0d", i + 2), cd[i+2], exp6[i]);
    end
    chk("int_rv1", cv[1], 32'd0);
    chk("int_dq1", cq[1], 32'd1);
    chk("int_dq7", cq[7], 32'd1);
    chk("int_rv8", cv[8], 32'd0);
    chk("int_dq8", cq[8], 32'd0);

    // Reset in the middle of a read burst
    issue(C_RD, 2'd2, 12'd0);
    tick(); tick();
    chk("pre_rst_rv", bus.RVALID, 32'd1);
    chk("pre_rst_d", bus.RDATA, 32'hC0DE_0001);
    RESET_N = 1'b0;
    #1;
    chk("abort_rv", bus.RVALID, 32'd0);
    chk("abort_dqs", bus.DQS_OE, 32'd0);
    chk("abort_rdata", bus.RDATA, 32'd0);
    chk("abort_ref", bus.REF_CNT, 32'd0);
    tick();
    RESET_N = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      acc = acc | bus.RVALID | bus.DQS_OE;
      tick();
    end
    chk("abort_stays", acc, 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
